// File: rtl/axi_chan_demux_1x2_if.sv
// rtl/axi_chan_demux_1x2_if.sv - upstream beat stream plus two downstream ports of the 1:2 channel demux
interface axi_chan_demux_1x2_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_sel;
  logic              m0_valid;
  logic              m0_ready;
  logic [DATA_W-1:0] m0_data;
  logic              m0_last;
  logic              m1_valid;
  logic              m1_ready;
  logic [DATA_W-1:0] m1_data;
  logic              m1_last;

  modport master (
    output s_valid, s_data, s_last, s_sel, m0_ready, m1_ready,
    input  s_ready, m0_valid, m0_data, m0_last, m1_valid, m1_data, m1_last
  );

  modport slave (
    input  s_valid, s_data, s_last, s_sel, m0_ready, m1_ready,
    output s_ready, m0_valid, m0_data, m0_last, m1_valid, m1_data, m1_last
  );
endinterface

// File: rtl/axi_chan_demux_1x2.sv
// rtl/axi_chan_demux_1x2.sv - registered 1:2 burst-locked channel demux
// Optional beat counters under macro AXI_DEMUX_BEAT_CNT_EN.
module axi_chan_demux_1x2 #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  enable,
  axi_chan_demux_1x2_if.slave   bus,
  output logic                  busy,
  output logic                  cur_sel,
  output logic [CNT_W-1:0]      cnt0,
  output logic [CNT_W-1:0]      cnt1
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q;
  logic              full_q;
  logic              dest_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  logic out_ready;
  logic accept;
  logic drain;
  logic v0;
  logic v1;

  assign out_ready   = dest_q ? bus.m1_ready : bus.m0_ready;
  // s_ready never looks at s_valid, so no combinational loop through upstream
  assign bus.s_ready = enable & ~ARESET & (~full_q | out_ready);
  assign accept      = bus.s_valid & bus.s_ready;
  assign drain       = full_q & out_ready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      full_q  <= 1'b0;
      dest_q  <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      if (accept) begin
        data_q <= bus.s_data;
        last_q <= bus.s_last;
        full_q <= 1'b1;
        case (state_q)
          IDLE: begin
            dest_q  <= bus.s_sel;
            state_q <= bus.s_last ? IDLE : BURST;
          end
          BURST: begin
            if (bus.s_last) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if (drain) begin
        full_q <= 1'b0;
      end
    end
  end

  assign v0 = full_q & ~dest_q;
  assign v1 = full_q & dest_q;

  assign bus.m0_valid = v0;
  assign bus.m0_data  = v0 ? data_q : '0;
  assign bus.m0_last  = v0 & last_q;
  assign bus.m1_valid = v1;
  assign bus.m1_data  = v1 ? data_q : '0;
  assign bus.m1_last  = v1 & last_q;

  assign busy    = (state_q == BURST) | full_q;
  assign cur_sel = dest_q;

`ifdef AXI_DEMUX_BEAT_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (v0 && bus.m0_ready && !(&cnt0_q)) cnt0_d = cnt0_q + ONE;
    if (v1 && bus.m1_ready && !(&cnt1_q)) cnt1_d = cnt1_q + ONE;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: doc/axi_chan_demux_1x2.md
Name: axi_chan_demux_1x2

Overview:
Registered 1-to-2 channel demultiplexer for the AXI interconnect datapath. It is the fan-out counterpart of the 2:1 enable-gated mux.
- Takes one upstream valid/ready/last beat stream and routes each burst to one of two downstream ports.
- The route is chosen by a select captured on the first beat of the burst and locked until the last beat.
- One output register stage gives full throughput and 1-cycle latency.
- Used on W/R-data fan-out paths between the arbiter and slave-side channels.

Parameters:
- DATA_W, 32, payload width in bits (s_data, m0_data, m1_data are [DATA_W-1:0]).
- CNT_W, 16, width of the optional beat counters.

Ports:
- ACLK  input  1  clock; all logic on rising edge.
- ARESET  input  1  synchronous active-high reset.
- enable  input  1  1 = accept new beats; 0 = s_ready forced low (held beat still drains).
- s_valid  input  1  upstream beat valid.
- s_ready  output  1  upstream beat accepted when s_valid & s_ready.
- s_data  input  DATA_W  upstream payload.
- s_last  input  1  last beat of burst.
- s_sel  input  1  destination (0 = port 0, 1 = port 1); sampled only on the first beat of a burst.
- m0_valid  output  1  port 0 beat valid.
- m0_ready  input  1  port 0 ready.
- m0_data  output  DATA_W  port 0 payload.
- m0_last  output  1  port 0 last.
- m1_valid  output  1  port 1 beat valid.
- m1_ready  input  1  port 1 ready.
- m1_data  output  DATA_W  port 1 payload.
- m1_last  output  1  port 1 last.
- busy  output  1  1 while a burst is open (state BURST) or the output register is full.
- cur_sel  output  1  locked destination of the open or last burst.
- cnt0  output  CNT_W  beats delivered on port 0 (optional feature).
- cnt1  output  CNT_W  beats delivered on port 1 (optional feature).

Behaviour:
- Reset (ARESET=1 at a clock edge) forces:
  - state=IDLE, full=0, dest_q=0, data/last register=0;
  - all m*_valid=0, m*_data=0, m*_last=0, s_ready=0 during reset, busy=0, cur_sel=0, cnt0=cnt1=0.
- Reset mid-burst discards the held beat and the open burst; no partial drain.
- Route state machine:
  - IDLE: an accepted beat latches dest_q<=s_sel.
    - If s_last=1, stay IDLE (single-beat burst).
    - Otherwise go to BURST.
  - BURST: accepted beats go to dest_q regardless of s_sel. An accepted beat with s_last=1 returns to IDLE.
- Output register:
  - full flag plus data/last/dest.
  - out_ready = dest_q ? m1_ready : m0_ready.
  - s_ready = enable & (~full | out_ready), registered-path free (combinational from full/ready only, never from s_valid).
  - Accept: register loads s_data/s_last, full<=1.
  - Drain without accept: full<=0.
  - Simultaneous drain and accept: register reloads, full stays 1. Gives back-to-back 1 beat/cycle.
- Outputs:
  - m0_valid = full & ~dest_q; m1_valid = full & dest_q.
  - The unselected port shows valid=0, data=0, last=0 (zeroed, never stale).
- Latency: a beat accepted at edge N is presented downstream from cycle N+1.
- Enable:
  - Dropping enable mid-burst does not abort the burst: BURST state and dest_q are held, the held beat still drains, and acceptance resumes on re-enable.
- Downstream stall: m*_ready low holds data/last stable with valid high (AXI rule); no beat loss or duplication.
- s_sel is ignored while in BURST; a change of s_sel there has no effect.
- cur_sel = dest_q.

Optional Feature:
- Macro AXI_DEMUX_BEAT_CNT_EN.
- Defined: cnt0/cnt1 increment by 1 on each m0/m1 handshake (valid & ready). They saturate at 2^CNT_W-1 (no wrap) and clear on ARESET.
- Undefined: counter logic is not compiled; cnt0=cnt1=0 constant.

Test Plan:
- Reset: ARESET=1 for 2 cycles with s_valid=1, s_data=32'hDEADBEEF → all m* outputs 0, busy=0, s_ready=0. After release, s_ready=1 (enable=1).
- Single beat: s_sel=1, s_data=32'h0000_00A5, s_last=1, m1_ready=1 → m1_valid=1 with data A5, last=1 exactly one cycle later. m0_valid stays 0; state returns to IDLE.
- Burst lock: 4-beat burst with s_sel=0 on beat 0, then s_sel toggled 1 on beats 1-3, data 1,2,3,4 → all 4 beats appear on port 0 in order, last on beat 4; m1_valid never 1.
- Backpressure: 8 beats to port 1 with m1_ready toggling 1,0,0,1… → beats delivered in order, no loss or duplicate; data stable while stalled. Throughput is 1 beat/cycle when m1_ready=1 continuously.
- Enable mid-burst: enable=0 after beat 2 of a 4-beat burst for 5 cycles → s_ready=0, held beat 2 drains, busy=1. After enable=1, beats 3-4 go to the same port.
- Counters (macro defined, CNT_W=4): 20 beats to port 0 → cnt0 saturates at 15, cnt1=0. Macro undefined → both read 0.
